// File: rtl/fp_div_job_master.sv
// fp_div_job_master
//
// Initiator for the double-precision divider's stb/ack operand/result links.
// One job at a time is taken from a valid/ready request port. Operand a and
// then operand b are handed to the divider, the quotient is collected, and the
// quotient is returned with the job tag on a valid/ready response port.
// A watchdog bounds the time from job acceptance to result capture. On expiry
// the divider is held in reset for a few cycles, and a quiet-NaN error
// response is returned.
//
// Ports:
//   clk, rst                    clock (posedge) and async active-high reset
//   req_valid/req_ready         upstream job handshake (ready only in IDLE)
//   req_a, req_b, req_tag       dividend, divisor (IEEE-754 double), job tag
//   rsp_valid/rsp_ready         downstream response handshake
//   rsp_z, rsp_tag, rsp_timeout quotient (or NaN), job tag, watchdog flag
//   div_a/div_a_stb/div_a_ack   operand a link to divider
//   div_b/div_b_stb/div_b_ack   operand b link to divider
//   div_z/div_z_stb/div_z_ack   result link from divider
//   div_rst                     reset request to divider (RECOVER only)
//   busy                        a job is in flight
//   job_count                   completed responses, wraps at 16 bits

module fp_div_job_master #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int RST_CYCLES     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_z,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic [63:0]      div_a,
    output logic             div_a_stb,
    input  logic             div_a_ack,
    output logic [63:0]      div_b,
    output logic             div_b_stb,
    input  logic             div_b_ack,
    input  logic [63:0]      div_z,
    input  logic             div_z_stb,
    output logic             div_z_ack,
    output logic             div_rst,
    output logic             busy,
    output logic [15:0]      job_count
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam logic [63:0] NAN_Z = 64'hFFF8_0000_0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        RECOVER,
        DELIVER
    } state_t;

    state_t state, state_next;

    logic [63:0]      a_q, b_q, z_q;
    logic [TAG_W-1:0] tag_q;
    logic             timeout_q;
    logic [WD_W-1:0]  wd_cnt;
    logic [RC_W-1:0]  rc_cnt;
    logic [15:0]      job_cnt_q;

    logic wd_expire;
    logic rc_done;

    // wd_cnt holds the number of divider-phase cycles already completed, so
    // the edge ending the TIMEOUT_CYCLES-th cycle sees TIMEOUT_CYCLES-1.
    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign rc_done   = (rc_cnt == RC_W'(RST_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. Every output is a decode of the
    // registered state, so a strobe drops in the cycle after its transfer.
    // In each divider phase the transfer is tested before the watchdog,
    // so a transfer on the expiry edge wins.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        div_a_stb  = 1'b0;
        div_b_stb  = 1'b0;
        div_z_ack  = 1'b0;
        div_rst    = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = SEND_A;
            end
            SEND_A: begin
                div_a_stb = 1'b1;
                if (div_a_ack)      state_next = SEND_B;
                else if (wd_expire) state_next = RECOVER;
            end
            SEND_B: begin
                div_b_stb = 1'b1;
                if (div_b_ack)      state_next = WAIT_Z;
                else if (wd_expire) state_next = RECOVER;
            end
            WAIT_Z: begin
                div_z_ack = 1'b1;
                if (div_z_stb)      state_next = DELIVER;
                else if (wd_expire) state_next = RECOVER;
            end
            RECOVER: begin
                div_rst = 1'b1;
                if (rc_done) state_next = DELIVER;
            end
            DELIVER: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Job data, result capture, watchdog, recovery timer and job counter.
    // The watchdog runs across all three divider phases without restarting
    // between them. It bounds the total time from acceptance to result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            z_q       <= '0;
            tag_q     <= '0;
            timeout_q <= 1'b0;
            wd_cnt    <= '0;
            rc_cnt    <= '0;
            job_cnt_q <= '0;
        end else begin
            rc_cnt <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q    <= req_a;
                        b_q    <= req_b;
                        tag_q  <= req_tag;
                        wd_cnt <= '0;
                    end
                end
                SEND_A, SEND_B: begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
                WAIT_Z: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (div_z_stb) begin
                        z_q       <= div_z;
                        timeout_q <= 1'b0;
                    end
                end
                RECOVER: begin
                    rc_cnt <= rc_cnt + 1'b1;
                    if (rc_done) begin
                        z_q       <= NAN_Z;
                        timeout_q <= 1'b1;
                    end
                end
                DELIVER: begin
                    if (rsp_ready) job_cnt_q <= job_cnt_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign div_a       = a_q;
    assign div_b       = b_q;
    assign rsp_z       = z_q;
    assign rsp_tag     = tag_q;
    assign rsp_timeout = timeout_q;
    assign job_count   = job_cnt_q;
    assign busy        = (state != IDLE);

endmodule
